// File: rtl/pool_max_seq.sv
// ---------------------------------------------------------------------------
// pool_max_seq
//
// Sequential 3x3 max-pooling engine. After a start request the block walks
// the nine 2x2 windows of a 4x4... (any) conv map in row-major order. Each
// cycle it drives the window select (r_cnt, c_cnt) to an external
// combinational mux (pool_mux_data), takes the signed maximum of the four
// returned values and stores it into its slot of pool_out. When the last
// window (2,2) is stored the result is presented with out_valid and held
// until the consumer accepts it with out_ready. A one-cycle done pulse
// follows acceptance.
//
// Configuration macro: POOL_RELU_EN
//   defined   -> every stored maximum is clamped to 0 when negative (ReLU).
//   undefined -> the signed maximum is stored unchanged.
//   Interface and timing are identical in both builds.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset (priority over all)
//   start      in   1  request one pooling pass; sampled in IDLE only
//   r_cnt      out  2  window row select to pool_mux_data
//   c_cnt      out  2  window column select to pool_mux_data
//   conv0..3   in   8  2x2 window values, signed two's complement
//   pool_out   out 72  pooled map, slot k = r*3+c at bits [k*8 +: 8]
//   out_valid  out  1  result available (held in HOLD)
//   out_ready  in   1  consumer accepts result; ignored while out_valid=0
//   busy       out  1  high in SCAN or HOLD
//   done       out  1  one-cycle pulse after the result handshake
// ---------------------------------------------------------------------------
module pool_max_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  r_cnt,
  output logic [1:0]  c_cnt,
  input  logic [7:0]  conv0,
  input  logic [7:0]  conv1,
  input  logic [7:0]  conv2,
  input  logic [7:0]  conv3,
  output logic [71:0] pool_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e      r_state;
  logic [1:0]  r_row;
  logic [1:0]  r_col;
  logic [71:0] r_pool;
  logic        r_valid;
  logic        r_done;

  logic signed [7:0] w_c0, w_c1, w_c2, w_c3;
  logic signed [7:0] w_max01, w_max23, w_max;
  logic [7:0]        w_store;
  logic [3:0]        w_slot;
  logic [6:0]        w_base;

  assign w_c0 = $signed(conv0);
  assign w_c1 = $signed(conv1);
  assign w_c2 = $signed(conv2);
  assign w_c3 = $signed(conv3);

  // Two-level signed compare tree; ties pass the common value through.
  always_comb begin
    w_max01 = (w_c0 > w_c1) ? w_c0 : w_c1;
    w_max23 = (w_c2 > w_c3) ? w_c2 : w_c3;
    w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
`ifdef POOL_RELU_EN
    w_store = w_max[7] ? 8'h00 : w_max;
`else
    w_store = w_max;
`endif
  end

  // Slot index r*3+c (0..8) and its bit offset in pool_out.
  assign w_slot = ({2'b00, r_row} << 1) + {2'b00, r_row} + {2'b00, r_col};
  assign w_base = {w_slot, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
      r_pool  <= 72'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StScan;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
          end
        end
        StScan: begin
          r_pool[w_base +: 8] <= w_store;
          if (r_col == 2'd2) begin
            r_col <= 2'd0;
            if (r_row == 2'd2) begin
              r_row   <= 2'd0;
              r_state <= StHold;
              r_valid <= 1'b1;
            end else begin
              r_row <= r_row + 2'd1;
            end
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        StHold: begin
          if (out_ready) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_row   <= 2'd0;
          r_col   <= 2'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign r_cnt     = r_row;
  assign c_cnt     = r_col;
  assign pool_out  = r_pool;
  assign out_valid = r_valid;
  assign done      = r_done;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_pool_max_seq.sv
// Bench for pool_max_seq: drives the window mux from a 3x3 table of 2x2
// windows, predicts the pooled map with plain signed arithmetic and checks
// sequencing, latency, hold behaviour, ignored requests and reset abort.
module tb_pool_max_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  r_cnt;
  logic [1:0]  c_cnt;
  logic [7:0]  conv0, conv1, conv2, conv3;
  logic [71:0] pool_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Window table: win[k][j] is element j of window k = r*3+c.
  logic [7:0] win [9][4];

  pool_max_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .r_cnt     (r_cnt),
    .c_cnt     (c_cnt),
    .conv0     (conv0),
    .conv1     (conv1),
    .conv2     (conv2),
    .conv3     (conv3),
    .pool_out  (pool_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for pool_mux_data: combinational window lookup.
  always_comb begin
    int k;
    k = int'(r_cnt) * 3 + int'(c_cnt);
    conv0 = 8'h00;
    conv1 = 8'h00;
    conv2 = 8'h00;
    conv3 = 8'h00;
    if (r_cnt < 2'd3 && c_cnt < 2'd3) begin
      conv0 = win[k][0];
      conv1 = win[k][1];
      conv2 = win[k][2];
      conv3 = win[k][3];
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] model_pool();
    logic [71:0] res;
    res = '0;
    for (int k = 0; k < 9; k++) begin
      int m;
      m = -1000;
      for (int j = 0; j < 4; j++) begin
        int v;
        v = int'($signed(win[k][j]));
        if (v > m) m = v;
      end
`ifdef POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      res[k*8 +: 8] = m[7:0];
    end
    return res;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 4; j++)
        win[k][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input logic [7:0] a, b, c, d);
    for (int k = 0; k < 9; k++) begin
      win[k][0] = a;
      win[k][1] = b;
      win[k][2] = c;
      win[k][3] = d;
    end
  endtask

  // Assumes we are at a negedge with the DUT idle. start_at_k: scan index
  // at which a stray start is pulsed (-1 for none). hold_n: cycles to wait
  // in HOLD before out_ready. start_in_hold: pulse start while holding.
  task automatic run_pass(input int start_at_k, input int hold_n, input bit start_in_hold);
    logic [71:0] exp;
    exp = model_pool();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("scan_rc", {68'd0, r_cnt, c_cnt}, {68'd0, 2'(k / 3), 2'(k % 3)});
      check("scan_busy_valid", {70'd0, busy, out_valid}, {70'd0, 2'b10});
      if (k == start_at_k) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("hold_valid", {71'd0, out_valid}, 72'd1);
    check("hold_pool", pool_out, exp);
    check("hold_rc", {68'd0, r_cnt, c_cnt}, 72'd0);
    for (int i = 0; i < hold_n; i++) begin
      if (start_in_hold && i == hold_n / 2) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("hold_stable", {69'd0, out_valid, busy, done}, {69'd0, 3'b110});
      check("hold_pool_stable", pool_out, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("handshake_flags", {69'd0, out_valid, busy, done}, {69'd0, 3'b001});
    check("idle_pool_kept", pool_out, exp);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", {71'd0, done}, 72'd0);
  endtask

  initial begin
    logic [71:0] exp;
    logic [71:0] pat;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fill_const(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pool", pool_out, 72'd0);
    check("reset_flags", {67'd0, r_cnt, c_cnt, out_valid, busy, done}, 72'd0);
    rst = 1'b0;
    // Ready while idle must be ignored.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_ignored", {70'd0, out_valid, done}, 72'd0);

    // Ascending windows: slot k gets k+3.
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 4; j++)
        win[k][j] = 8'(k + j);
    pat = '0;
    for (int k = 0; k < 9; k++) pat[k*8 +: 8] = 8'(k + 3);
    check("model_ascending", model_pool(), pat);
    run_pass(4, 20, 1'b1);
    check("ascending_result", pool_out, pat);

    // All negative windows.
    fill_const(8'hFB, 8'hFE, 8'hF7, 8'h80);
    run_pass(-1, 2, 1'b0);
`ifdef POOL_RELU_EN
    check("neg_slot0", {64'd0, pool_out[7:0]}, 72'h00);
`else
    check("neg_slot0", {64'd0, pool_out[7:0]}, 72'hFE);
`endif

    // Extremes: -128 vs 127.
    fill_const(8'h80, 8'h7F, 8'h00, 8'h00);
    run_pass(-1, 0, 1'b0);
    check("extreme_slot8", {64'd0, pool_out[71:64]}, 72'h7F);

    // Ties.
    fill_const(8'hC3, 8'hC3, 8'hC3, 8'hC3);
    run_pass(-1, 1, 1'b0);

    // Random passes.
    for (int p = 0; p < 6; p++) begin
      fill_random();
      run_pass(int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 5)), 1'($urandom));
    end

    // Reset in the middle of a scan aborts the pass.
    fill_random();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst       = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_pool", pool_out, 72'd0);
    check("abort_flags", {67'd0, r_cnt, c_cnt, out_valid, busy, done}, 72'd0);
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_no_done", {70'd0, busy, done}, 72'd0);

    // Start in the first cycle after reset release is accepted.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    exp = model_pool();
    run_pass(-1, 3, 1'b0);
    check("after_abort_result", pool_out, exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
